rename_regfile: RTL and testbench
=================================

// Module: rename_regfile
// PURPOSE
//  Parametrised architectural register file with per-register rename tags (ROB ids) and busy bits.
//  Sits between decode/issue (rename port, NRD source-read ports) and the ROB commit stage (NCOMMIT write ports).
//  Successor to the single-commit, 2-read file: adds configurable width/depth/ports, multi-commit ordering, and a registered pending-register count.
// PARAMETERS
//  XLEN     32  data width
//  NREG     32  architectural registers; reg 0 hardwired zero; power of 2
//  TAG_W    5   ROB tag width
//  NRD      2   combinational source-read ports
//  NCOMMIT  2   commit ports; higher index = younger in program order
//  localparam AW = $clog2(NREG), CW = AW+1
// PORTS
//  clk        in   1              clock
//  rst        in   1              async reset, active-low
//  rdy        in   1              global enable; 0 = hold all state
//  flush      in   1              sync mispredict flush
//  ren_en     in   1              rename dest register
//  ren_addr   in   AW             dest reg
//  ren_tag    in   TAG_W          ROB tag allocated to dest
//  cm_en      in   NCOMMIT        commit valid per port
//  cm_addr    in   NCOMMIT*AW     commit dest reg, port i at [i*AW+:AW]
//  cm_tag     in   NCOMMIT*TAG_W  committing ROB tag
//  cm_data    in   NCOMMIT*XLEN   committed value
//  rd_en      in   NRD            read enable per port
//  rd_addr    in   NRD*AW         source reg
//  rd_data    out  NRD*XLEN       value (valid when rd_rdy)
//  rd_tag     out  NRD*TAG_W      producer tag when not ready, else 0
//  rd_rdy     out  NRD            1 = value final, 0 = wait on rd_tag
//  pend_cnt   out  CW             registered count of busy registers
// BEHAVIOUR
//  Reset (rst=0, async): all data=0, tags=0, busy=0, pend_cnt=0. Read outputs are combinational: all 0 while rst=0.
//  State updates occur only on posedge clk with rdy=1; rdy=0 freezes state (reads stay live).
//  Commit, port i: if cm_en[i] and cm_addr!=0, write data[cm_addr]. Same addr on several ports: highest index wins data.
//  Busy clear: on commit i, if tag[cm_addr]==cm_tag[i] (pre-update tag), clear busy, unless same-cycle rename hits that reg.
//  Rename: if ren_en, ren_addr!=0, !flush: tag<=ren_tag, busy<=1. Rename beats commit busy-clear on the same reg.
//  Address 0: writes, renames and busy-sets are ignored.
//  Flush: busy<=all 0, tags unchanged. Same-cycle commits still write data. Same-cycle rename is dropped.
//  Reads, port p, priority order:
//   rst=0 or flush=1 -> data 0, rdy 0, tag 0.
//   rd_en=0 -> all 0.
//   addr==0 -> data 0, rdy 1, tag 0.
//   Commit bypass: any cm_en[i] with cm_addr==addr and cm_tag==tag[addr] -> data=cm_data[i] (highest such i), rdy 1, tag 0.
//   Otherwise -> data=regs[addr], rdy=!busy[addr], tag = busy ? tag[addr] : 0.
//  Reads never see a same-cycle rename (sources are read before the dest is renamed).
//  pend_cnt: next cycle = popcount of next busy vector. Range 0..NREG-1. Held when rdy=0. Zeroed by flush next cycle.
//  Tag reuse: a commit whose tag mismatches the current tag writes data but leaves busy set (a younger writer is pending).
// TESTING
//  Reset, read r5 -> data 0, rdy 1, tag 0. Read r0 any time -> data 0, rdy 1.
//  Rename r3 tag 7; next cycle read r3 -> rdy 0, tag 7, pend_cnt 1. Commit r3 tag 7 data 0xAB:
//   same-cycle read -> 0xAB, rdy 1 (bypass); next cycle -> rdy 1, pend_cnt 0.
//  Rename r4 tag 2, then r4 tag 9; commit r4 tag 2 data 0x11 -> regs=0x11, busy stays, read tag 9.
//   Then commit tag 9 data 0x22 -> rdy 1, data 0x22.
//  Same cycle: commit r6 tag 1 (port 0, 0x1) and r6 tag 3 (port 1, 0x3), current tag 3 -> data 0x3, busy cleared.
//  Same cycle: rename r8 tag 4 and commit r8 with the old matching tag -> busy stays 1, tag 4, data updated.
//  Rename r1, r2, r7; assert flush with commit r9 0x55 -> next cycle all rdy 1, pend_cnt 0, r9=0x55, tags unchanged.
//   rdy=0 with rename -> no change. rst low mid-run -> outputs 0 immediately, state cleared.

Source files
------------

// File: rtl/rename_regfile.sv
// Architectural register file with rename tags and busy bits; reads combinational (with commit bypass), updates 1 cycle.
// No backpressure: rdy=0 freezes all state while reads stay live.
module rename_regfile #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int TAG_W   = 5,
  parameter int NRD     = 2,
  parameter int NCOMMIT = 2,
  localparam int AW     = $clog2(NREG),
  localparam int CW     = AW + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     ren_en,
  input  logic [AW-1:0]            ren_addr,
  input  logic [TAG_W-1:0]         ren_tag,
  input  logic [NCOMMIT-1:0]       cm_en,
  input  logic [NCOMMIT*AW-1:0]    cm_addr,
  input  logic [NCOMMIT*TAG_W-1:0] cm_tag,
  input  logic [NCOMMIT*XLEN-1:0]  cm_data,
  input  logic [NRD-1:0]           rd_en,
  input  logic [NRD*AW-1:0]        rd_addr,
  output logic [NRD*XLEN-1:0]      rd_data,
  output logic [NRD*TAG_W-1:0]     rd_tag,
  output logic [NRD-1:0]           rd_rdy,
  output logic [CW-1:0]            pend_cnt
);

  logic [XLEN-1:0]  regs [NREG];
  logic [TAG_W-1:0] tags [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             ren_ok;

  assign ren_ok = ren_en && (ren_addr != '0) && !flush;

  // Busy clear compares against the pre-update tag; a same-cycle rename overrides it.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NCOMMIT; i++) begin
      if (cm_en[i] && (cm_addr[i*AW+:AW] != '0) &&
          (tags[cm_addr[i*AW+:AW]] == cm_tag[i*TAG_W+:TAG_W]))
        busy_nxt[cm_addr[i*AW+:AW]] = 1'b0;
    end
    if (ren_ok)
      busy_nxt[ren_addr] = 1'b1;
    if (flush)
      busy_nxt = '0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NREG; r++)
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
  end

  // Ascending port order means the youngest commit to a register lands last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        tags[r] <= '0;
      end
      busy     <= '0;
      pend_cnt <= '0;
    end else if (rdy) begin
      for (int i = 0; i < NCOMMIT; i++) begin
        if (cm_en[i] && (cm_addr[i*AW+:AW] != '0))
          regs[cm_addr[i*AW+:AW]] <= cm_data[i*XLEN+:XLEN];
      end
      if (ren_ok)
        tags[ren_addr] <= ren_tag;
      busy     <= busy_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]    a;
    logic             hit;
    logic [XLEN-1:0]  byp;
    logic [XLEN-1:0]  d;
    logic [TAG_W-1:0] t;
    logic             r;

    assign a = rd_addr[p*AW+:AW];

    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int i = 0; i < NCOMMIT; i++) begin
        if (cm_en[i] && (cm_addr[i*AW+:AW] == a) &&
            (cm_tag[i*TAG_W+:TAG_W] == tags[a])) begin
          hit = 1'b1;
          byp = cm_data[i*XLEN+:XLEN];
        end
      end
    end

    always_comb begin
      d = '0;
      t = '0;
      r = 1'b0;
      if (rst && !flush && rd_en[p]) begin
        if (a == '0) begin
          r = 1'b1;
        end else if (hit) begin
          d = byp;
          r = 1'b1;
        end else begin
          d = regs[a];
          r = !busy[a];
          t = busy[a] ? tags[a] : '0;
        end
      end
    end

    assign rd_data[p*XLEN+:XLEN]  = d;
    assign rd_tag[p*TAG_W+:TAG_W] = t;
    assign rd_rdy[p]              = r;
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: each task drives one scenario and checks inline against hand-computed values.
module tb_rename_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        ren_en;
  logic [4:0]  ren_addr;
  logic [4:0]  ren_tag;
  logic [1:0]  cm_en;
  logic [9:0]  cm_addr;
  logic [9:0]  cm_tag;
  logic [63:0] cm_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [9:0]  rd_tag;
  logic [1:0]  rd_rdy;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int failures = 0;

  rename_regfile dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .ren_en(ren_en), .ren_addr(ren_addr), .ren_tag(ren_tag),
    .cm_en(cm_en), .cm_addr(cm_addr), .cm_tag(cm_tag), .cm_data(cm_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_tag(rd_tag),
    .rd_rdy(rd_rdy), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    flush = 0; ren_en = 0; ren_addr = 0; ren_tag = 0;
    cm_en = 0; cm_addr = 0; cm_tag = 0; cm_data = 0;
    rd_en = 0; rd_addr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ren(input int a, input int t);
    ren_en = 1; ren_addr = 5'(a); ren_tag = 5'(t);
  endtask

  task automatic cmt(input int p, input int a, input int t, input logic [31:0] d);
    cm_en[p] = 1'b1;
    cm_addr[p*5+:5] = 5'(a);
    cm_tag[p*5+:5] = 5'(t);
    cm_data[p*32+:32] = d;
  endtask

  task automatic rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*5+:5] = 5'(a);
  endtask

  task automatic test_reset();
    rst = 0; rdy = 1; idle();
    rd(0, 5); rd(1, 0);
    #12;
    checks++; if (rd_rdy !== 2'b00) begin failures++; $display("FAIL rst_rd_rdy got=%b exp=00", rd_rdy); end
    checks++; if (pend_cnt !== 6'd0) begin failures++; $display("FAIL rst_pend got=%0d exp=0", pend_cnt); end
    rst = 1;
    #1;
    checks++; if (rd_data[31:0] !== 32'h0 || rd_rdy[0] !== 1'b1 || rd_tag[4:0] !== 5'd0) begin
      failures++; $display("FAIL r5_after_reset got data=%h rdy=%b tag=%0d exp data=0 rdy=1 tag=0", rd_data[31:0], rd_rdy[0], rd_tag[4:0]); end
    checks++; if (rd_data[63:32] !== 32'h0 || rd_rdy[1] !== 1'b1) begin
      failures++; $display("FAIL r0_read got data=%h rdy=%b exp data=0 rdy=1", rd_data[63:32], rd_rdy[1]); end
    step();
  endtask

  task automatic test_rename_commit();
    idle(); ren(3, 7); step();
    idle(); rd(0, 3); #1;
    checks++; if (rd_rdy[0] !== 1'b0 || rd_tag[4:0] !== 5'd7) begin
      failures++; $display("FAIL r3_busy got rdy=%b tag=%0d exp rdy=0 tag=7", rd_rdy[0], rd_tag[4:0]); end
    checks++; if (pend_cnt !== 6'd1) begin failures++; $display("FAIL r3_pend got=%0d exp=1", pend_cnt); end
    cmt(0, 3, 7, 32'hAB); #1;
    checks++; if (rd_data[31:0] !== 32'hAB || rd_rdy[0] !== 1'b1 || rd_tag[4:0] !== 5'd0) begin
      failures++; $display("FAIL r3_bypass got data=%h rdy=%b tag=%0d exp data=ab rdy=1 tag=0", rd_data[31:0], rd_rdy[0], rd_tag[4:0]); end
    step();
    idle(); rd(0, 3); #1;
    checks++; if (rd_data[31:0] !== 32'hAB || rd_rdy[0] !== 1'b1 || pend_cnt !== 6'd0) begin
      failures++; $display("FAIL r3_committed got data=%h rdy=%b pend=%0d exp data=ab rdy=1 pend=0", rd_data[31:0], rd_rdy[0], pend_cnt); end
  endtask

  task automatic test_tag_reuse();
    idle(); ren(4, 2); step();
    idle(); ren(4, 9); step();
    idle(); cmt(0, 4, 2, 32'h11); rd(0, 4); #1;
    checks++; if (rd_rdy[0] !== 1'b0 || rd_tag[4:0] !== 5'd9 || rd_data[31:0] !== 32'h0) begin
      failures++; $display("FAIL r4_stale_nobypass got data=%h rdy=%b tag=%0d exp data=0 rdy=0 tag=9", rd_data[31:0], rd_rdy[0], rd_tag[4:0]); end
    step();
    idle(); rd(0, 4); #1;
    checks++; if (rd_data[31:0] !== 32'h11 || rd_rdy[0] !== 1'b0 || rd_tag[4:0] !== 5'd9 || pend_cnt !== 6'd1) begin
      failures++; $display("FAIL r4_stale_commit got data=%h rdy=%b tag=%0d pend=%0d exp data=11 rdy=0 tag=9 pend=1", rd_data[31:0], rd_rdy[0], rd_tag[4:0], pend_cnt); end
    cmt(1, 4, 9, 32'h22); step();
    idle(); rd(0, 4); #1;
    checks++; if (rd_data[31:0] !== 32'h22 || rd_rdy[0] !== 1'b1 || pend_cnt !== 6'd0) begin
      failures++; $display("FAIL r4_final got data=%h rdy=%b pend=%0d exp data=22 rdy=1 pend=0", rd_data[31:0], rd_rdy[0], pend_cnt); end
  endtask

  task automatic test_multi_commit();
    idle(); ren(6, 3); step();
    idle(); cmt(0, 6, 1, 32'h1); cmt(1, 6, 3, 32'h3); rd(1, 6); #1;
    checks++; if (rd_data[63:32] !== 32'h3 || rd_rdy[1] !== 1'b1) begin
      failures++; $display("FAIL r6_dual_bypass got data=%h rdy=%b exp data=3 rdy=1", rd_data[63:32], rd_rdy[1]); end
    step();
    idle(); rd(0, 6); #1;
    checks++; if (rd_data[31:0] !== 32'h3 || rd_rdy[0] !== 1'b1 || pend_cnt !== 6'd0) begin
      failures++; $display("FAIL r6_dual_commit got data=%h rdy=%b pend=%0d exp data=3 rdy=1 pend=0", rd_data[31:0], rd_rdy[0], pend_cnt); end
    // Older port owns the matching tag; younger port still wins the data.
    idle(); ren(6, 3); step();
    idle(); cmt(0, 6, 3, 32'h5); cmt(1, 6, 1, 32'h6); rd(0, 6); #1;
    checks++; if (rd_data[31:0] !== 32'h5 || rd_rdy[0] !== 1'b1) begin
      failures++; $display("FAIL r6_port0_bypass got data=%h rdy=%b exp data=5 rdy=1", rd_data[31:0], rd_rdy[0]); end
    step();
    idle(); rd(0, 6); #1;
    checks++; if (rd_data[31:0] !== 32'h6 || rd_rdy[0] !== 1'b1 || pend_cnt !== 6'd0) begin
      failures++; $display("FAIL r6_young_data got data=%h rdy=%b pend=%0d exp data=6 rdy=1 pend=0", rd_data[31:0], rd_rdy[0], pend_cnt); end
  endtask

  task automatic test_rename_vs_commit();
    idle(); ren(8, 5); step();
    idle(); ren(8, 4); cmt(0, 8, 5, 32'h77); step();
    idle(); rd(0, 8); #1;
    checks++; if (rd_data[31:0] !== 32'h77 || rd_rdy[0] !== 1'b0 || rd_tag[4:0] !== 5'd4 || pend_cnt !== 6'd1) begin
      failures++; $display("FAIL r8_rename_wins got data=%h rdy=%b tag=%0d pend=%0d exp data=77 rdy=0 tag=4 pend=1", rd_data[31:0], rd_rdy[0], rd_tag[4:0], pend_cnt); end
    cmt(0, 8, 4, 32'h78); step();
    idle();
  endtask

  task automatic test_flush();
    idle(); ren(1, 1); step();
    idle(); ren(2, 2); step();
    idle(); ren(7, 3); step();
    idle(); rd(0, 2); #1;
    checks++; if (pend_cnt !== 6'd3 || rd_rdy[0] !== 1'b0) begin
      failures++; $display("FAIL pre_flush got pend=%0d rdy=%b exp pend=3 rdy=0", pend_cnt, rd_rdy[0]); end
    idle(); flush = 1; cmt(0, 9, 0, 32'h55); ren(10, 6); rd(0, 9); #1;
    checks++; if (rd_data[31:0] !== 32'h0 || rd_rdy[0] !== 1'b0) begin
      failures++; $display("FAIL flush_read got data=%h rdy=%b exp data=0 rdy=0", rd_data[31:0], rd_rdy[0]); end
    step();
    idle(); rd(0, 1); rd(1, 9); #1;
    checks++; if (rd_rdy !== 2'b11 || rd_tag !== 10'd0 || rd_data[63:32] !== 32'h55 || pend_cnt !== 6'd0) begin
      failures++; $display("FAIL post_flush got rdy=%b tag=%h r9=%h pend=%0d exp rdy=11 tag=0 r9=55 pend=0", rd_rdy, rd_tag, rd_data[63:32], pend_cnt); end
    idle(); rd(0, 10); cmt(0, 2, 2, 32'h99); rd(1, 2); #1;
    checks++; if (rd_rdy[0] !== 1'b1 || rd_data[63:32] !== 32'h99) begin
      failures++; $display("FAIL flush_tags_kept got r10rdy=%b r2=%h exp r10rdy=1 r2=99", rd_rdy[0], rd_data[63:32]); end
    step();
    idle();
  endtask

  task automatic test_hold();
    idle(); rdy = 0; ren(11, 5); cmt(0, 12, 0, 32'h33); step();
    idle(); rdy = 1; rd(0, 11); rd(1, 12); #1;
    checks++; if (rd_rdy !== 2'b11 || rd_data[63:32] !== 32'h0 || pend_cnt !== 6'd0) begin
      failures++; $display("FAIL hold got rdy=%b r12=%h pend=%0d exp rdy=11 r12=0 pend=0", rd_rdy, rd_data[63:32], pend_cnt); end
  endtask

  task automatic test_back_to_back();
    idle(); ren(13, 1); step();
    idle(); ren(14, 2); cmt(1, 15, 0, 32'h44); step();
    idle(); ren(0, 3); step();
    idle(); rd(0, 0); rd(1, 15); #1;
    checks++; if (pend_cnt !== 6'd2 || rd_rdy !== 2'b11 || rd_data[31:0] !== 32'h0 || rd_data[63:32] !== 32'h44) begin
      failures++; $display("FAIL b2b got pend=%0d rdy=%b r0=%h r15=%h exp pend=2 rdy=11 r0=0 r15=44", pend_cnt, rd_rdy, rd_data[31:0], rd_data[63:32]); end
  endtask

  task automatic test_async_reset();
    idle(); rd(0, 13); rd(1, 15);
    @(posedge clk); #3;
    rst = 0; #1;
    checks++; if (rd_rdy !== 2'b00 || rd_data !== 64'h0 || pend_cnt !== 6'd0) begin
      failures++; $display("FAIL async_rst got rdy=%b data=%h pend=%0d exp all 0", rd_rdy, rd_data, pend_cnt); end
    #2; rst = 1; #1;
    checks++; if (rd_rdy !== 2'b11 || rd_tag !== 10'd0 || rd_data[63:32] !== 32'h0) begin
      failures++; $display("FAIL post_rst got rdy=%b tag=%h r15=%h exp rdy=11 tag=0 r15=0", rd_rdy, rd_tag, rd_data[63:32]); end
    step();
  endtask

  initial begin
    test_reset();
    test_rename_commit();
    test_tag_reuse();
    test_multi_commit();
    test_rename_vs_commit();
    test_flush();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
